polygon_vertex_streamer: RTL and testbench
==========================================

// Module: polygon_vertex_streamer
// PURPOSE
//  Downstream consumer of Polygon_List: snapshots the 12 fixed-point triangles (3 vertices x 4 homogeneous
//  coords, Q(WOI).(WOF)) on start and serializes them one vertex per transfer over a valid/ready stream.
//  Feeds the vertex transform/projection stage; one start = one frame's worth of geometry.
// PARAMETERS
//  WOI       9   integer bits of each coordinate (signed fixed point)
//  WOF       16  fractional bits of each coordinate
//  NUM_POLY  12  polygons per frame (must match Polygon_List output count)
// PORTS
//  clock       in   1                          system clock, all logic on rising edge
//  resetn      in   1                          asynchronous, active-low reset
//  start       in   1                          begin a frame; honoured only in IDLE
//  poly_list   in   [NUM_POLY-1:0][2:0][3:0][W-1:0]  all polygons, W=WOI+WOF; Poly(k+1) -> index k
//  vert_out    out  [3:0][W-1:0]               current vertex {w,z,y,x}, coord[0]=x
//  vert_idx    out  2                          vertex within polygon, 0..2
//  poly_idx    out  4                          polygon index, 0..NUM_POLY-1
//  out_valid   out  1                          vert_out/indices valid
//  out_ready   in   1                          downstream accepts when out_valid&&out_ready
//  poly_last   out  1                          vert_idx==2 (qualified by out_valid)
//  frame_last  out  1                          last vertex of last streamed polygon
//  busy        out  1                          high from accepted start until after final transfer
//  done        out  1                          one-cycle pulse the cycle after the final transfer
// BEHAVIOUR
//  - Reset (async, resetn=0): state=IDLE; all outputs 0; snapshot register cleared; counters 0.
//  - FSM IDLE -> STREAM -> DONE -> IDLE.
//    IDLE: start=1 -> capture poly_list into snapshot, poly_idx=first poly, vert_idx=0, go STREAM.
//    STREAM: out_valid=1; on transfer: vert_idx<2 -> vert_idx+1; else next poly, vert_idx=0;
//      transfer with frame_last=1 -> go DONE, out_valid=0 next cycle.
//    DONE: done=1 for exactly one cycle, busy=0, return to IDLE (start in DONE is ignored).
//  - Latency: start at cycle N -> out_valid=1 with vertex 0 of poly 0 at N+1.
//  - Throughput: 1 vertex/cycle with out_ready held high; 36-cycle frame for NUM_POLY=12.
//  - Handshake: once out_valid=1, vert_out/vert_idx/poly_idx/flags hold stable until transfer;
//    out_valid never drops without a transfer (except reset).
//  - vert_out is taken from the snapshot; poly_list changes after start do not affect the frame.
//  - start while busy is ignored (no restart, no queueing).
//  - Coordinates passed bit-exact; no arithmetic on data; index counters never exceed limits (no wrap).
//  - Reset mid-frame: stream aborts immediately, out_valid=0, no done pulse.
// CONFIGURATION
//  POLY_MASK_EN defined: extra input poly_mask [NUM_POLY-1:0], sampled with start; polygons with mask
//    bit 0 are skipped with no bubble cycles; poly_idx reports the original index; frame_last marks the
//    highest enabled polygon. All-zero mask: no out_valid, busy for 1 cycle, done pulses at N+2.
//  Not defined: port absent; all NUM_POLY polygons streamed in index order.
// STRUCTURE
//  poly_pkg: WOI, WOF, W, NUM_POLY, VERTS=3, COORDS=4; typedef coord_t [W-1:0], vertex_t [3:0] coord_t,
//    poly_t [2:0] vertex_t, poly_list_t [NUM_POLY-1:0] poly_t; state enum {IDLE,STREAM,DONE}.
//  Sub-module poly_next_sel (only with POLY_MASK_EN): combinational first-set-bit-above-index finder
//    returning next enabled index and a none-left flag.
// TESTING
//  1 Reset: resetn=0 mid-sim -> all outputs 0 asynchronously; release, idle 5 cycles -> out_valid=0.
//  2 Full frame, out_ready=1: start pulse at N -> 36 transfers N+1..N+36, poly_idx 0..11, vert_idx 0,1,2
//    cycle; frame_last only at (11,2); done=1 at N+37 only; vert_out matches Poly1..Poly12 bit-exact.
//  3 Backpressure: out_ready random 50% -> same 36-vertex sequence, outputs stable while stalled.
//  4 Start while busy: second start at N+10 ignored; poly_list changed at N+5 -> stream unchanged.
//  5 Reset at transfer 20 -> out_valid=0 immediately, no done; new start -> frame restarts at poly 0.
//  6 POLY_MASK_EN, mask=12'b1000_0000_0101 -> polys 0,2,11 only, 9 transfers, frame_last at (11,2);
//    mask=0 -> no out_valid, done at N+2.

Source files
------------

// File: rtl/poly_pkg.sv
// Shared types and sizes for the polygon vertex streamer.
// Fixed-point coordinate format, polygon list layout and FSM states.
package poly_pkg;

  localparam int WOI      = 9;
  localparam int WOF      = 16;
  localparam int W        = WOI + WOF;
  localparam int NUM_POLY = 12;
  localparam int VERTS    = 3;
  localparam int COORDS   = 4;

  typedef logic [W-1:0] coord_t;
  typedef coord_t [3:0] vertex_t;
  typedef vertex_t [2:0] poly_t;
  typedef poly_t [NUM_POLY-1:0] poly_list_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

endpackage

// File: rtl/poly_next_sel.sv
// First-set-bit finder: lowest mask index >= from (built only with POLY_MASK_EN).
// Ports: mask, from -> idx (next enabled polygon), none (no enabled polygon left).
`ifdef POLY_MASK_EN
module poly_next_sel #(
  parameter int N  = 12,
  parameter int IW = 4
) (
  input  logic [N-1:0]  mask,
  input  logic [IW:0]   from,
  output logic [IW-1:0] idx,
  output logic          none
);

  // Scan downward so the lowest qualifying index wins.
  always_comb begin
    idx  = '0;
    none = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] && ((IW+1)'(i) >= from)) begin
        idx  = IW'(i);
        none = 1'b0;
      end
    end
  end

endmodule
`endif

// File: rtl/polygon_vertex_streamer.sv
// Snapshots a frame of polygons on start and streams one vertex per valid/ready transfer.
// Ports: clock, resetn, start, poly_list in; vert_out, vert_idx, poly_idx, out_valid, poly_last,
// frame_last, busy, done out; out_ready in. POLY_MASK_EN adds poly_mask to skip polygons.
import poly_pkg::*;

module polygon_vertex_streamer #(
  parameter int WOI      = poly_pkg::WOI,
  parameter int WOF      = poly_pkg::WOF,
  parameter int NUM_POLY = poly_pkg::NUM_POLY
) (
  input  logic clock,
  input  logic resetn,
  input  logic start,
  input  logic [NUM_POLY-1:0][2:0][3:0][WOI+WOF-1:0] poly_list,
`ifdef POLY_MASK_EN
  input  logic [NUM_POLY-1:0] poly_mask,
`endif
  output logic [3:0][WOI+WOF-1:0] vert_out,
  output logic [1:0] vert_idx,
  output logic [3:0] poly_idx,
  output logic out_valid,
  input  logic out_ready,
  output logic poly_last,
  output logic frame_last,
  output logic busy,
  output logic done
);

  logic [NUM_POLY-1:0][2:0][3:0][WOI+WOF-1:0] snap;
  state_t state;

  logic [3:0] first_p;
  logic       first_none;
  logic [3:0] nxt_p;
  logic       nxt_none;

`ifdef POLY_MASK_EN
  logic [NUM_POLY-1:0] mask_q;

  poly_next_sel #(.N(NUM_POLY), .IW(4)) u_first (
    .mask (poly_mask),
    .from (5'd0),
    .idx  (first_p),
    .none (first_none)
  );

  poly_next_sel #(.N(NUM_POLY), .IW(4)) u_next (
    .mask (mask_q),
    .from ({1'b0, poly_idx} + 5'd1),
    .idx  (nxt_p),
    .none (nxt_none)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) mask_q <= '0;
    else if (state == IDLE && start) mask_q <= poly_mask;
  end
`else
  assign first_p    = 4'd0;
  assign first_none = 1'b0;
  assign nxt_p      = poly_idx + 4'd1;
  assign nxt_none   = (poly_idx == 4'(NUM_POLY - 1));
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      snap       <= '0;
      vert_out   <= '0;
      vert_idx   <= '0;
      poly_idx   <= '0;
      out_valid  <= 1'b0;
      poly_last  <= 1'b0;
      frame_last <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            snap       <= poly_list;
            vert_out   <= poly_list[first_p][0];
            poly_idx   <= first_p;
            vert_idx   <= 2'd0;
            poly_last  <= 1'b0;
            frame_last <= 1'b0;
            out_valid  <= !first_none;
            busy       <= 1'b1;
            state      <= STREAM;
          end
        end
        STREAM: begin
          // Empty frame (all polygons masked): finish without streaming.
          if (!out_valid) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (out_ready) begin
            if (frame_last) begin
              out_valid  <= 1'b0;
              poly_last  <= 1'b0;
              frame_last <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              state      <= DONE;
            end else if (vert_idx != 2'd2) begin
              vert_idx   <= vert_idx + 2'd1;
              vert_out   <= snap[poly_idx][vert_idx + 2'd1];
              poly_last  <= (vert_idx == 2'd1);
              frame_last <= (vert_idx == 2'd1) && nxt_none;
            end else begin
              poly_idx   <= nxt_p;
              vert_idx   <= 2'd0;
              vert_out   <= snap[nxt_p][0];
              poly_last  <= 1'b0;
              frame_last <= 1'b0;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_polygon_vertex_streamer.sv
// Directed self-checking bench for polygon_vertex_streamer.
// Covers reset, full frame, backpressure, ignored restart, mid-frame reset, optional masking.
module tb_polygon_vertex_streamer;

  logic clock = 0;
  logic resetn = 0;
  logic start = 0;
  logic out_ready = 0;
  logic [11:0][2:0][3:0][24:0] poly_list;
`ifdef POLY_MASK_EN
  logic [11:0] poly_mask = '1;
`endif
  logic [3:0][24:0] vert_out;
  logic [1:0] vert_idx;
  logic [3:0] poly_idx;
  logic out_valid, poly_last, frame_last, busy, done;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  polygon_vertex_streamer dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .poly_list  (poly_list),
`ifdef POLY_MASK_EN
    .poly_mask  (poly_mask),
`endif
    .vert_out   (vert_out),
    .vert_idx   (vert_idx),
    .poly_idx   (poly_idx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .poly_last  (poly_last),
    .frame_last (frame_last),
    .busy       (busy),
    .done       (done)
  );

  function automatic logic [24:0] pat(int k, int v, int c);
    logic [24:0] r;
    r = 25'(k * 65536 + v * 4096 + c * 256 + 8'h5A);
    if (c[0]) r = r ^ 25'h1000000;
    return r;
  endfunction

  function automatic logic [3:0][24:0] vtx(int k, int v);
    logic [3:0][24:0] r;
    for (int c = 0; c < 4; c++) r[c] = pat(k, v, c);
    return r;
  endfunction

  task automatic load_list(input logic inv);
    for (int k = 0; k < 12; k++)
      for (int v = 0; v < 3; v++)
        for (int c = 0; c < 4; c++)
          poly_list[k][v][c] = inv ? ~pat(k, v, c) : pat(k, v, c);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_vtx(input int p, input int v, input logic fl);
    chk("valid", 128'(out_valid), 128'(1));
    chk("poly_idx", 128'(poly_idx), 128'(p));
    chk("vert_idx", 128'(vert_idx), 128'(v));
    chk("vert_out", 128'(vert_out), 128'(vtx(p, v)));
    chk("poly_last", 128'(poly_last), 128'(v == 2));
    chk("frame_last", 128'(frame_last), 128'(fl));
    chk("busy", 128'(busy), 128'(1));
    chk("done_low", 128'(done), 128'(0));
  endtask

  task automatic chk_done;
    chk("done", 128'(done), 128'(1));
    chk("busy_end", 128'(busy), 128'(0));
    chk("valid_end", 128'(out_valid), 128'(0));
    tick();
    chk("done_pulse", 128'(done), 128'(0));
  endtask

  initial begin
    int n;
    int cyc;
    load_list(1'b0);

    // 1: reset
    #2;
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_vert", 128'(vert_out), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    tick();
    resetn = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("idle_valid", 128'(out_valid), 128'(0));
    chk("idle_busy", 128'(busy), 128'(0));

    // 2: full frame, out_ready held high
    out_ready = 1;
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 36; i++) begin
      chk_vtx(i / 3, i % 3, i == 35);
      tick();
    end
    chk_done();

    // 3: random backpressure
    n = 0;
    cyc = 0;
    start = 1;
    tick();
    start = 0;
    while (n < 36 && cyc < 1000) begin
      out_ready = 1'($urandom_range(0, 1));
      chk_vtx(n / 3, n % 3, n == 35);
      if (out_ready) n++;
      cyc++;
      tick();
    end
    chk("bp_count", 128'(n), 128'(36));
    out_ready = 1;
    chk_done();

    // 4: start while busy ignored, poly_list change does not leak
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 36; i++) begin
      if (i == 5) load_list(1'b1);
      start = (i == 10);
      chk_vtx(i / 3, i % 3, i == 35);
      tick();
    end
    start = 0;
    chk_done();
    for (int i = 0; i < 3; i++) begin
      chk("no_restart", 128'(out_valid), 128'(0));
      tick();
    end
    load_list(1'b0);

    // 5: reset at transfer 20, then a clean frame
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 20; i++) begin
      chk_vtx(i / 3, i % 3, 1'b0);
      tick();
    end
    chk_vtx(6, 2, 1'b0);
    resetn = 0;
    #1;
    chk("mr_valid", 128'(out_valid), 128'(0));
    chk("mr_busy", 128'(busy), 128'(0));
    chk("mr_vert", 128'(vert_out), 128'(0));
    tick();
    resetn = 1;
    for (int i = 0; i < 3; i++) begin
      chk("mr_nodone", 128'(done), 128'(0));
      tick();
    end
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 36; i++) begin
      chk_vtx(i / 3, i % 3, i == 35);
      tick();
    end
    chk_done();

`ifdef POLY_MASK_EN
    // 6: masked frames
    begin
      int sel[3] = '{0, 2, 11};
      poly_mask = 12'b1000_0000_0101;
      start = 1;
      tick();
      start = 0;
      poly_mask = '1;
      for (int j = 0; j < 9; j++) begin
        chk_vtx(sel[j / 3], j % 3, j == 8);
        tick();
      end
      chk_done();
      poly_mask = '0;
      start = 1;
      tick();
      start = 0;
      chk("m0_valid", 128'(out_valid), 128'(0));
      chk("m0_busy", 128'(busy), 128'(1));
      chk("m0_done1", 128'(done), 128'(0));
      tick();
      chk("m0_done2", 128'(done), 128'(1));
      chk("m0_busy2", 128'(busy), 128'(0));
      chk("m0_valid2", 128'(out_valid), 128'(0));
      poly_mask = '1;
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
